// File: rtl/ariane_pkg.sv
// Shared store-queue types and default sizing constants.
// Entry bundle and parameter defaults used by the store queue slice.
package ariane_pkg;

   localparam int unsigned SQ_DEPTH    = 8;
   localparam int unsigned SQ_ADDR_W   = 64;
   localparam int unsigned SQ_DATA_W   = 64;
   localparam int unsigned SQ_BE_W     = SQ_DATA_W / 8;
   localparam int unsigned SQ_OFFSET_W = 12;

   typedef struct packed {
      logic [SQ_ADDR_W-1:0] addr;
      logic [SQ_DATA_W-1:0] data;
      logic [SQ_BE_W-1:0]   be;
      logic [1:0]           size;
   } sq_entry_t;

endpackage

// File: rtl/sq_alias_match.sv
// One store entry versus one load: same 8-byte word within the page
// offset and at least one overlapping byte lane.
module sq_alias_match
   import ariane_pkg::*;
#(
   parameter int unsigned OFFSET_W = SQ_OFFSET_W,
   parameter int unsigned BE_W     = SQ_BE_W,
   localparam int unsigned LINE_W  = OFFSET_W - 3
) (
   input  logic              valid_i,
   input  logic [LINE_W-1:0] st_line_i,
   input  logic [BE_W-1:0]   st_be_i,
   input  logic [LINE_W-1:0] ld_line_i,
   input  logic [BE_W-1:0]   ld_be_i,
   output logic              match_o
);

   assign match_o = valid_i
                  & (st_line_i == ld_line_i)
                  & (|(st_be_i & ld_be_i));

endmodule

// File: rtl/store_queue.sv
// Store queue: speculative and committed stores in one circular buffer,
// drained in order to memory, with a page-offset alias check for loads.
module store_queue
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH    = SQ_DEPTH,
   parameter int unsigned ADDR_W   = SQ_ADDR_W,
   parameter int unsigned DATA_W   = SQ_DATA_W,
   parameter int unsigned OFFSET_W = SQ_OFFSET_W,
   localparam int unsigned BE_W    = DATA_W / 8,
   localparam int unsigned IDX_W   = $clog2(DEPTH),
   localparam int unsigned PTR_W   = IDX_W + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ADDR_W-1:0]     paddr_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic [BE_W-1:0]       be_i,
   input  logic [1:0]            size_i,
   input  logic                  commit_i,
   output logic                  commit_ready_o,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic [ADDR_W-1:0]     req_addr_o,
   output logic [DATA_W-1:0]     req_data_o,
   output logic [BE_W-1:0]       req_be_o,
   output logic [1:0]            req_size_o,
   input  logic [OFFSET_W-1:0]   ld_offset_i,
   input  logic [BE_W-1:0]       ld_be_i,
   output logic                  ld_match_o,
   output logic                  no_st_pending_o,
   output logic [$clog2(DEPTH):0] occupancy_o
);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  cmt_q, cmt_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  occ, n_cmt, n_spec;
   logic [IDX_W-1:0]  head_idx, tail_idx;
   logic              push, pop, cmt_fire;
   logic [DEPTH-1:0]  live, hit;
   logic              unused_ld_lsb;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [BE_W-1:0]   be_q   [DEPTH];
   logic [BE_W-1:0]   be_d   [DEPTH];
   logic [1:0]        size_q [DEPTH];
   logic [1:0]        size_d [DEPTH];

   assign head_idx = head_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];

   assign occ    = tail_q - head_q;
   assign n_cmt  = cmt_q - head_q;
   assign n_spec = tail_q - cmt_q;

   // occupancy never exceeds DEPTH, so its MSB alone marks full
   assign ready_o         = ~occ[IDX_W];
   assign commit_ready_o  = |n_spec;
   assign req_valid_o     = |n_cmt;
   assign no_st_pending_o = ~|occ;
   assign occupancy_o     = occ;

   assign push     = valid_i & ready_o & ~flush_i;
   assign cmt_fire = commit_i & commit_ready_o;
   assign pop      = req_valid_o & req_ready_i;

   assign req_addr_o = addr_q[head_idx];
   assign req_data_o = data_q[head_idx];
   assign req_be_o   = be_q[head_idx];
   assign req_size_o = size_q[head_idx];

   always_comb begin
      head_d = head_q + PTR_W'(pop);
      cmt_d  = cmt_q + PTR_W'(cmt_fire);
      tail_d = flush_i ? cmt_d : tail_q + PTR_W'(push);
      addr_d = addr_q;
      data_d = data_q;
      be_d   = be_q;
      size_d = size_q;
      if (push) begin
         addr_d[tail_idx] = paddr_i;
         data_d[tail_idx] = data_i;
         be_d[tail_idx]   = be_i;
         size_d[tail_idx] = size_i;
      end
   end

   // an entry is held when its distance from head is below occupancy
   always_comb begin
      live = '0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = {1'b0, IDX_W'(i) - head_idx} < occ;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_alias
      sq_alias_match #(
         .OFFSET_W (OFFSET_W),
         .BE_W     (BE_W)
      ) u_match (
         .valid_i   (live[g]),
         .st_line_i (addr_q[g][OFFSET_W-1:3]),
         .st_be_i   (be_q[g]),
         .ld_line_i (ld_offset_i[OFFSET_W-1:3]),
         .ld_be_i   (ld_be_i),
         .match_o   (hit[g])
      );
   end

   assign ld_match_o    = |hit;
   assign unused_ld_lsb = ^ld_offset_i[2:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
            size_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         cmt_q  <= cmt_d;
         tail_q <= tail_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
            be_q[i]   <= be_d[i];
            size_q[i] <= size_d[i];
         end
      end
   end

endmodule
